// File: rtl/tb_pattern_gen.sv
// Packet pattern generator: fixed-length packets separated by idle gaps, valid/ready handshake.
// Define TB_PATTERN_GEN_LFSR_EN for 16-bit Fibonacci LFSR payload instead of the word counter.
module tb_pattern_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16,
  parameter int GAP        = 2,
  parameter int NUM_PKTS   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  sop,
  output logic                  eop,
  output logic [15:0]           pkt_count,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP_WAIT, DONE} state_t;

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP - 1);
  localparam logic [15:0] PKT_LIMIT = 16'(NUM_PKTS);
`ifdef TB_PATTERN_GEN_LFSR_EN
  localparam logic [15:0] WORD_SEED = 16'h0001;
`else
  localparam logic [15:0] WORD_SEED = '0;
`endif

  state_t      state_q, state_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] word_q, word_d;
  logic [15:0] pkt_q, pkt_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] word_next;

`ifdef TB_PATTERN_GEN_LFSR_EN
  assign word_next = {word_q[14:0], word_q[15] ^ word_q[13] ^ word_q[12] ^ word_q[10]};
`else
  assign word_next = word_q + 16'd1;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    word_d  = word_q;
    pkt_d   = pkt_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (enable) state_d = SEND;
      end
      SEND: begin
        if (ready) begin
          word_d = word_next;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            pkt_d  = pkt_q + 16'd1;
            gap_d  = '0;
            // enable only matters here, at the packet boundary
            if (NUM_PKTS != 0 && pkt_d == PKT_LIMIT) state_d = DONE;
            else if (GAP > 0)                        state_d = GAP_WAIT;
            else if (enable)                         state_d = SEND;
            else                                     state_d = IDLE;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      GAP_WAIT: begin
        if (gap_q == GAP_LAST) state_d = enable ? SEND : IDLE;
        else                   gap_d   = gap_q + 8'd1;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      word_q  <= WORD_SEED;
      pkt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
    end
  end

  assign valid     = (state_q == SEND);
  assign sop       = valid && (beat_q == '0);
  assign eop       = valid && (beat_q == LAST_BEAT);
  assign data      = valid ? word_q[DATA_WIDTH-1:0] : '0;
  assign pkt_count = pkt_q;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_tb_pattern_gen.sv
// Scoreboard bench for tb_pattern_gen: default instance plus a GAP=0/PKT_LEN=1, 16-bit instance.
module tb_tb_pattern_gen;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic d_reset = 1'b1, d_enable = 1'b0, d_ready = 1'b1;
  logic d_valid, d_sop, d_eop, d_done;
  logic [7:0]  d_data;
  logic [15:0] d_pkt;

  logic b_reset = 1'b1, b_enable = 1'b0, b_ready = 1'b1;
  logic b_valid, b_sop, b_eop, b_done;
  logic [15:0] b_data;
  logic [15:0] b_pkt;

  tb_pattern_gen u_dut (
    .clock(clock), .reset(d_reset), .enable(d_enable), .ready(d_ready),
    .valid(d_valid), .data(d_data), .sop(d_sop), .eop(d_eop),
    .pkt_count(d_pkt), .done(d_done)
  );

  tb_pattern_gen #(.DATA_WIDTH(16), .PKT_LEN(1), .GAP(0), .NUM_PKTS(0)) u_b2b (
    .clock(clock), .reset(b_reset), .enable(b_enable), .ready(b_ready),
    .valid(b_valid), .data(b_data), .sop(b_sop), .eop(b_eop),
    .pkt_count(b_pkt), .done(b_done)
  );

  int total = 0;
  int bad   = 0;

  beat_t dq[$];
  beat_t bq[$];
  logic [15:0] d_mw, b_mw, exp_eop_data, last_eop_data;
  int d_idx = 0, b_idx = 0;
  int stall_idx = -1, stall_left = 0, hold_cnt = 0;
  int drop_idx = -1, rst_idx = -1, b_drop_idx = -1;
  bit rst_hit = 0, gap_trk = 0, b_run = 0, b_seen = 0;
  int idle_cnt = 0;

  function automatic logic [15:0] seed();
`ifdef TB_PATTERN_GEN_LFSR_EN
    return 16'h0001;
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] nxt(input logic [15:0] w);
`ifdef TB_PATTERN_GEN_LFSR_EN
    return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
`else
    return w + 16'd1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_d(input int n);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.data = {8'h00, d_mw[7:0]};
      e.sop  = (i % 16 == 0);
      e.eop  = (i % 16 == 15);
      if (i == 15) exp_eop_data = e.data;
      dq.push_back(e);
      d_mw = nxt(d_mw);
    end
  endtask

  task automatic push_b(input int n);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.data = b_mw;
      e.sop  = 1'b1;
      e.eop  = 1'b1;
      bq.push_back(e);
      b_mw = nxt(b_mw);
    end
  endtask

  // One cycle: apply index-triggered input hooks at the negedge, then score what is presented.
  task automatic tick();
    beat_t e;
    @(negedge clock);
    if (d_valid && d_idx == stall_idx && stall_left > 0) begin
      d_ready = 1'b0;
      stall_left--;
    end else begin
      d_ready = 1'b1;
    end
    if (d_valid && d_idx == drop_idx) begin d_enable = 1'b0; drop_idx = -1; end
    if (d_valid && d_idx == rst_idx)  begin d_reset = 1'b1; rst_idx = -1; rst_hit = 1; end
    if (b_valid && b_idx == b_drop_idx) begin b_enable = 1'b0; b_drop_idx = -1; end

    if (d_reset) begin
      gap_trk = 0;
    end else begin
      if (d_valid && d_idx == stall_idx) begin
        hold_cnt++;
        if (dq.size() > 0) check("hold_data", {24'h0, d_data}, {16'h0, dq[0].data});
      end
      if (d_valid && gap_trk) begin
        check("gap_len", idle_cnt, 2);
        gap_trk = 0;
      end else if (!d_valid && gap_trk) begin
        idle_cnt++;
      end
      if (d_valid && d_ready) begin
        if (dq.size() == 0) begin
          check("d_extra_beat", {31'h0, d_valid}, 0);
        end else begin
          e = dq.pop_front();
          check("d_data", {24'h0, d_data}, {16'h0, e.data});
          check("d_sop", {31'h0, d_sop}, {31'h0, e.sop});
          check("d_eop", {31'h0, d_eop}, {31'h0, e.eop});
        end
        if (d_eop) begin
          last_eop_data = {8'h00, d_data};
          gap_trk = 1;
          idle_cnt = 0;
        end
        d_idx++;
      end
    end

    if (!b_reset) begin
      if (b_run && b_seen) check("b_valid_cont", {31'h0, b_valid}, 1);
      if (b_valid && b_ready) begin
        b_seen = 1;
        if (bq.size() == 0) begin
          check("b_extra_beat", {31'h0, b_valid}, 0);
        end else begin
          e = bq.pop_front();
          check("b_data", {16'h0, b_data}, {16'h0, e.data});
          check("b_sop", {31'h0, b_sop}, 1);
          check("b_eop", {31'h0, b_eop}, 1);
        end
        b_idx++;
      end
    end
  endtask

  task automatic reset_d();
    d_reset = 1'b1;
    d_enable = 1'b0;
    tick();
    tick();
    d_reset = 1'b0;
    d_mw = seed();
    d_idx = 0;
    dq.delete();
  endtask

  initial begin
    d_mw = seed();
    b_mw = seed();

    // reset state
    tick();
    tick();
    check("rst_valid", {31'h0, d_valid}, 0);
    check("rst_sop", {31'h0, d_sop}, 0);
    check("rst_eop", {31'h0, d_eop}, 0);
    check("rst_data", {24'h0, d_data}, 0);
    check("rst_pkt", {16'h0, d_pkt}, 0);
    check("rst_done", {31'h0, d_done}, 0);

    // full run of 4 packets x 16 beats, ready always high
    reset_d();
    push_d(64);
    d_enable = 1'b1;
    for (int i = 0; i < 300 && !d_done; i++) tick();
    check("run_done", {31'h0, d_done}, 1);
    check("run_pkt", {16'h0, d_pkt}, 4);
    check("run_q_empty", dq.size(), 0);
    d_enable = 1'b0;
    tick();
    d_enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("done_valid", {31'h0, d_valid}, 0);
    check("done_hold", {31'h0, d_done}, 1);

    // stall on beat 5 and drop enable at beat 3: one full packet then IDLE
    reset_d();
    push_d(16);
    d_enable = 1'b1;
    stall_idx = 5;
    stall_left = 2;
    hold_cnt = 0;
    drop_idx = 3;
    for (int i = 0; i < 40; i++) tick();
    stall_idx = -1;
    check("hold_cycles", hold_cnt, 3);
    check("drop_q_empty", dq.size(), 0);
    check("drop_eop_data", {16'h0, last_eop_data}, {16'h0, exp_eop_data});
    check("drop_pkt", {16'h0, d_pkt}, 1);
    check("drop_idle_valid", {31'h0, d_valid}, 0);
    check("drop_done", {31'h0, d_done}, 0);

    // reset at beat 7 abandons the packet
    reset_d();
    push_d(7);
    d_enable = 1'b1;
    rst_idx = 7;
    rst_hit = 0;
    for (int i = 0; i < 50 && !rst_hit; i++) tick();
    check("rst7_hit", {31'h0, rst_hit}, 1);
    tick();
    check("rst7_valid", {31'h0, d_valid}, 0);
    check("rst7_pkt", {16'h0, d_pkt}, 0);
    check("rst7_eop", {31'h0, d_eop}, 0);
    check("rst7_q_empty", dq.size(), 0);
    d_reset = 1'b0;
    d_mw = seed();
    d_idx = 0;
    dq.delete();
    push_d(16);
    d_enable = 1'b1;
    drop_idx = 0;
    for (int i = 0; i < 10 && !d_valid; i++) tick();
    check("restart_data", {24'h0, d_data}, {16'h0, seed() & 16'h00ff});
    check("restart_sop", {31'h0, d_sop}, 1);
    for (int i = 0; i < 30; i++) tick();
    check("restart_q_empty", dq.size(), 0);

    // back-to-back single-beat packets, 16-bit data
    b_reset = 1'b0;
    b_mw = seed();
    push_b(20);
    b_enable = 1'b1;
    b_drop_idx = 19;
    b_run = 1;
    for (int i = 0; i < 30 && bq.size() > 0; i++) tick();
    b_run = 0;
    check("b2b_q_empty", bq.size(), 0);
    tick();
    tick();
    check("b2b_stop_valid", {31'h0, b_valid}, 0);
    check("b2b_pkt", {16'h0, b_pkt}, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
